// File: rtl/store_narrow_unit_if.sv
// Store request / data-memory port bundle for store_narrow_unit.
// The slave side is the store unit; the master side is the pipeline plus memory.
interface store_narrow_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [1:0]  size;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_read_data;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic        done;
    logic        error;

    modport slave (
        input  req_valid, address, write_data, size, mem_read_data,
        output req_ready, mem_address, mem_read, mem_write, mem_write_data, done, error
    );

    modport master (
        output req_valid, address, write_data, size, mem_read_data,
        input  req_ready, mem_address, mem_read, mem_write, mem_write_data, done, error
    );
endinterface

// File: rtl/store_narrow_unit.sv
// Narrows a 32-bit register value to byte/halfword/word and commits it to
// word-organised data memory. Sub-word stores read the word, merge the new
// lanes (little-endian) and write the full word back.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; captures address/data/size on accept
// READ  | sub-word store: read strobe for the containing word
// WRITE | full-word write of merged data (or plain data for a word store)
// DONE  | one-cycle completion pulse; error reflects the captured flag
module store_narrow_unit (
    input  logic          clk,
    input  logic          reset,
    store_narrow_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        err_q;

    logic        accept;
    logic        req_err;
    logic [3:0]  lane_en;
    logic [31:0] lane_data;
    logic [31:0] merged;

    // Requests are only taken in IDLE; everything else ignores the inputs.
    assign accept = bus.req_valid && (state_q == IDLE);

    // Legality of the incoming request: illegal size or misaligned access.
    always_comb begin
        req_err = 1'b0;
        case (bus.size)
            SIZE_BYTE: req_err = 1'b0;
            SIZE_HALF: req_err = bus.address[0];
            SIZE_WORD: req_err = |bus.address[1:0];
            default:   req_err = 1'b1;
        endcase
    end

    // State register and request capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= bus.address;
                wdata_q <= bus.write_data;
                size_q  <= bus.size;
                err_q   <= req_err;
            end
        end
    end

    // Next-state selection; word stores skip the read, errors skip memory.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_d = DONE;
                    end else if (bus.size == SIZE_WORD) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:    state_d = WRITE;
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane enables and replicated store data, then merge over the read word.
    always_comb begin
        lane_en   = 4'b0000;
        lane_data = wdata_q;
        case (size_q)
            SIZE_BYTE: begin
                lane_en   = 4'b0001 << addr_q[1:0];
                lane_data = {4{wdata_q[7:0]}};
            end
            SIZE_HALF: begin
                lane_en   = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata_q[15:0]}};
            end
            SIZE_WORD: begin
                lane_en   = 4'b1111;
                lane_data = wdata_q;
            end
            default: begin
                lane_en   = 4'b0000;
                lane_data = wdata_q;
            end
        endcase
        merged = bus.mem_read_data;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
                merged[8*i +: 8] = lane_data[8*i +: 8];
            end
        end
    end

    // Outputs decoded from state; all held low while reset is asserted so an
    // in-flight write is suppressed in the reset cycle itself.
    always_comb begin
        bus.req_ready      = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.done           = 1'b0;
        bus.error          = 1'b0;
        bus.mem_address    = 32'd0;
        bus.mem_write_data = 32'd0;
        if (!reset) begin
            bus.req_ready   = (state_q == IDLE);
            bus.mem_read    = (state_q == READ);
            bus.mem_write   = (state_q == WRITE);
            bus.done        = (state_q == DONE);
            bus.error       = (state_q == DONE) && err_q;
            bus.mem_address = {addr_q[31:2], 2'b00};
            if (state_q == WRITE) begin
                bus.mem_write_data = merged;
            end
        end
    end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Testbench for store_narrow_unit: directed cases plus random stores checked
// against a byte-array reference model and a small memory model.
module tb_store_narrow_unit;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   cyc;

    store_narrow_unit_if bus();

    store_narrow_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model: one-cycle read latency, word writes, tb-side loading.
    logic [31:0] dut_mem [0:63];
    logic [31:0] exp_mem [0:63];
    logic [31:0] rd_q;
    logic        init_en;
    logic [5:0]  init_idx;
    logic [31:0] init_val;

    assign bus.mem_read_data = rd_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to measure accept spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory behaviour seen by the unit.
    always @(posedge clk) begin
        if (init_en) begin
            dut_mem[init_idx] <= init_val;
        end else if (bus.mem_write) begin
            dut_mem[bus.mem_address[7:2]] <= bus.mem_write_data;
        end
        if (bus.mem_read) begin
            rd_q <= dut_mem[bus.mem_address[7:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic ref_err(input logic [31:0] a, input logic [1:0] s);
        case (s)
            2'd0:    return 1'b0;
            2'd1:    return (a % 2) != 0;
            2'd2:    return (a % 4) != 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] a,
                                              input logic [31:0] d, input logic [1:0] s);
        logic [7:0]  b [4];
        logic [31:0] r;
        int          nb;
        int          off;
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        nb  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        off = int'(a % 4);
        for (int i = 0; i < nb; i++) b[off + i] = d[8*i +: 8];
        r = {b[3], b[2], b[1], b[0]};
        return r;
    endfunction

    task automatic load_word(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        init_en  = 1'b1;
        init_idx = a[7:2];
        init_val = v;
        @(negedge clk);
        init_en  = 1'b0;
        exp_mem[a[7:2]] = v;
    endtask

    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        logic        e;
        int          n;
        int          guard;
        logic [5:0]  idx;
        logic [31:0] new_word;
        logic        exp_rd;
        logic        exp_wr;
        e        = ref_err(a, s);
        n        = e ? 1 : ((s == 2'd2) ? 2 : 3);
        idx      = a[7:2];
        new_word = e ? exp_mem[idx] : ref_store(exp_mem[idx], a, d, s);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.address    = a;
        bus.write_data = d;
        bus.size       = s;
        guard = 0;
        while (!bus.req_ready && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_wait", 32'(guard < 16), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.address    = $urandom;
        bus.write_data = $urandom;
        bus.size       = 2'($urandom_range(0, 3));
        for (int c = 1; c <= n; c++) begin
            exp_rd = !e && (s != 2'd2) && (c == 1);
            exp_wr = !e && (c == n - 1);
            chk("mem_read", 32'(bus.mem_read), 32'(exp_rd));
            chk("mem_write", 32'(bus.mem_write), 32'(exp_wr));
            chk("done", 32'(bus.done), 32'(c == n));
            chk("error", 32'(bus.error), 32'((c == n) && e));
            if (exp_rd || exp_wr) chk("mem_address", bus.mem_address, {a[31:2], 2'b00});
            if (exp_wr) chk("write_data", bus.mem_write_data, new_word);
            @(negedge clk);
        end
        chk("ready_after", 32'(bus.req_ready), 32'd1);
        chk("done_after", 32'(bus.done), 32'd0);
        exp_mem[idx] = new_word;
        chk("mem_word", dut_mem[idx], new_word);
    endtask

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          guard;
        int          t1;
        int          t2;
        logic [31:0] a;
        logic [1:0]  s;
        total = 0;
        bad   = 0;
        cyc   = 0;
        init_en = 1'b0;
        init_idx = 6'd0;
        init_val = 32'd0;
        rd_q = 32'd0;
        reset = 1'b1;
        bus.req_valid  = 1'b1;
        bus.address    = 32'h100;
        bus.write_data = 32'hFFFF_FFFF;
        bus.size       = 2'd0;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_strobes", {29'd0, bus.mem_read, bus.mem_write, bus.done}, 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        chk("rst_addr", bus.mem_address, 32'd0);
        chk("rst_wdata", bus.mem_write_data, 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 8; i++) load_word(32'h100 + 32'(4 * i), $urandom);

        // Directed cases.
        load_word(32'h100, 32'h1122_3344);
        run_store(32'h101, 32'hAABB_CCDD, 2'd0);
        chk("byte_result", dut_mem[0], 32'h1122_DD44);
        load_word(32'h100, 32'h1122_3344);
        run_store(32'h102, 32'h0000_BEEF, 2'd1);
        chk("half_result", dut_mem[0], 32'hBEEF_3344);
        run_store(32'h104, 32'hCAFE_F00D, 2'd2);
        chk("word_result", dut_mem[1], 32'hCAFE_F00D);
        run_store(32'h103, 32'h1234_5678, 2'd1);
        run_store(32'h106, 32'h1234_5678, 2'd2);
        run_store(32'h100, 32'h1234_5678, 2'd3);
        chk("err_no_write", dut_mem[0], 32'hBEEF_3344);

        // Reset while in WRITE abandons the store.
        load_word(32'h100, 32'h1122_3344);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.address    = 32'h101;
        bus.write_data = 32'h0000_0099;
        bus.size       = 2'd0;
        guard = 0;
        while (!bus.req_ready && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rw_read", 32'(bus.mem_read), 32'd1);
        @(negedge clk);
        chk("rw_write_pre", 32'(bus.mem_write), 32'd1);
        reset = 1'b1;
        #1;
        chk("rw_write_rst", 32'(bus.mem_write), 32'd0);
        chk("rw_wdata_rst", bus.mem_write_data, 32'd0);
        chk("rw_addr_rst", bus.mem_address, 32'd0);
        chk("rw_ready_rst", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rw_ready_after", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rw_no_done", 32'(bus.done), 32'd0);
        end
        chk("rw_mem_kept", dut_mem[0], 32'h1122_3344);

        // Back-to-back byte stores with req_valid held high.
        load_word(32'h100, 32'h1122_3344);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.address    = 32'h100;
        bus.write_data = 32'h0000_0055;
        bus.size       = 2'd0;
        guard = 0;
        while (!bus.req_ready && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 t1 = cyc;
        @(negedge clk);
        bus.address    = 32'h103;
        bus.write_data = 32'h0000_0066;
        guard = 0;
        while (!bus.req_ready && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 t2 = cyc;
        chk("b2b_spacing", 32'(t2 - t1), 32'd4);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        exp_mem[0] = ref_store(ref_store(32'h1122_3344, 32'h100, 32'h55, 2'd0), 32'h103, 32'h66, 2'd0);
        chk("b2b_result", dut_mem[0], 32'h6622_3355);
        chk("b2b_model", dut_mem[0], exp_mem[0]);

        // Random stores across eight words.
        for (int i = 0; i < 60; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 31));
            s = 2'($urandom_range(0, 3));
            run_store(a, $urandom, s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_narrow_unit.md
# store_narrow_unit

Store-path partner of the load sign/zero-extension logic. Takes a 32-bit register value plus a byte address and a size code (byte, halfword, word), narrows the value to the selected width, and commits it to word-organised data memory. Sub-word stores use a read-modify-write sequence. The block sits between the MEM-stage store request and the data-memory port, and signals completion or misalignment to the pipeline control.

## Interface
Parameters:
- none; all widths are fixed at 32-bit data and 32-bit byte address.

Ports:
- Clk  input  1  single clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high; sampled on the rising edge of Clk.
- ReqValid  input  1  store request present.
- ReqReady  output  1  block can accept a request; high only in IDLE.
- Address  input  32  byte address of the store.
- WriteData  input  32  register value; only the low 8/16/32 bits are stored.
- Size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- MemAddress  output  32  word-aligned address, equal to {Address[31:2], 2'b00} of the captured request.
- MemRead  output  1  read strobe; memory returns MemReadData in the next cycle.
- MemReadData  input  32  word read from memory.
- MemWrite  output  1  full-word write strobe.
- MemWriteData  output  32  word to write.
- Done  output  1  one-cycle completion pulse.
- Error  output  1  valid with Done; 1 = request rejected, no memory write.

## Operation
- Byte-lane order is little-endian: offset 0 maps to [7:0], offset 1 to [15:8], offset 2 to [23:16], offset 3 to [31:24].
- Handshake: a request is accepted on an edge where ReqValid=1 and ReqReady=1. Address, WriteData and Size are captured into registers at that edge. Inputs are ignored in every other state.
- Error conditions, evaluated at acceptance:
  - Size=11.
  - Halfword with Address[0]=1.
  - Word with Address[1:0]≠00.
- FSM states are IDLE, READ, WRITE and DONE.
- Transitions:
  - IDLE to READ on accept of a legal byte or halfword store.
  - IDLE to WRITE on accept of a legal word store.
  - IDLE to DONE on accept of an erroneous request, with the Error register set.
  - READ to WRITE unconditionally.
  - WRITE to DONE unconditionally.
  - DONE to IDLE unconditionally.
- READ: MemRead=1, MemAddress valid.
- WRITE: MemWrite=1, MemAddress valid. MemWriteData is:
  - byte: MemReadData with the lane at Address[1:0] replaced by WriteData[7:0];
  - halfword: MemReadData with lanes {Address[1],0} and {Address[1],1} replaced by WriteData[15:0];
  - word: WriteData.
- MemReadData is used combinationally in WRITE only.
- DONE: Done=1; Error holds the captured error flag.
- MemRead, MemWrite and Done are never high outside their own states. MemRead and MemWrite are never high together.
- Reset values:
  - State is IDLE.
  - The Error register and the captured request registers are 0.
  - While Reset=1, all outputs are forced to 0: ReqReady, MemRead, MemWrite, Done, Error, MemAddress and MemWriteData.
- Reset mid-operation: the in-flight store is abandoned. If Reset=1 during WRITE, MemWrite is low that cycle and no write occurs. Done is not pulsed for an abandoned request.

## Timing
- Accept edge is k. Cycles below are counted after k.
- Byte or halfword store: READ in cycle k+1, WRITE in k+2, DONE in k+3, ReqReady=1 again in k+4. Four cycles per store.
- Word store: WRITE in k+1, DONE in k+2, ready again in k+3.
- Erroneous request: DONE with Error=1 in k+1, ready again in k+2. No MemRead or MemWrite.
- First ReqReady=1 is in the first cycle after Reset is sampled low.
- ReqValid held high across DONE is accepted at the first IDLE edge. Back-to-back throughput therefore has no extra bubbles.

## Test plan
- Byte store: memory[0x100]=0x11223344; request Size=00, Address=0x101, WriteData=0xAABBCCDD. Expected: MemRead at k+1 with MemAddress=0x100; MemWrite at k+2 with 0x1122DD44; Done=1, Error=0 at k+3.
- Halfword store: memory[0x100]=0x11223344; request Size=01, Address=0x102, WriteData=0x0000BEEF. Expected: MemWrite data 0xBEEF3344 at k+2.
- Word store: request Size=10, Address=0x104, WriteData=0xCAFEF00D. Expected: no MemRead; MemWrite at k+1 with MemAddress=0x104 and data 0xCAFEF00D; Done at k+2.
- Misaligned and illegal requests: Size=01 at 0x103, Size=10 at 0x106, Size=11 at 0x100. Expected: each gives Done=1, Error=1 at k+1; MemRead and MemWrite stay 0.
- Reset in WRITE: a byte store is interrupted by Reset=1 in cycle k+2. Expected: MemWrite=0 in that cycle; memory unchanged; no Done; ReqReady=1 in the cycle after Reset drops.
- Back-to-back stores: ReqValid held high for two byte stores at 0x100 offsets 0 then 3 (data 0x55, then 0x66) on memory 0x11223344. Expected: the second accept occurs 4 cycles after the first; final memory word is 0x66223355.
